// File: rtl/dmg_timer_pkg.sv
// Shared types and constants for the TIMA/TMA/TAC timer controller.
package dmg_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OVF    = 2'd1,
    RELOAD = 2'd2
  } t_timer_state;

  localparam logic [1:0] A_TIMA = 2'd1;
  localparam logic [1:0] A_TMA  = 2'd2;
  localparam logic [1:0] A_TAC  = 2'd3;

  localparam logic [4:0] TAC_READ_PAD = 5'b11111;

  // div_taps bit index for each TAC[1:0] frequency select
  localparam logic [1:0] TAP_4096   = 2'd0;
  localparam logic [1:0] TAP_262144 = 2'd1;
  localparam logic [1:0] TAP_65536  = 2'd2;
  localparam logic [1:0] TAP_16384  = 2'd3;

endpackage

// File: rtl/timer_tap_edge.sv
// Divider tap mux gated by the TAC enable, plus falling-edge detector producing tick.
// Optional TIMER_TESTMODE_EN adds ff60_d1, which forces tick every cycle.
module timer_tap_edge
  import dmg_timer_pkg::*;
(
  input  logic       clk1,
  input  logic       reset,
  input  logic [3:0] div_taps,
  input  logic [2:0] tac,
`ifdef TIMER_TESTMODE_EN
  input  logic       ff60_d1,
`endif
  output logic       tick
);

  logic sel;
  logic sel_q;

  // Disabling TAC or resetting the divider can drop sel and tick; that is deliberate.
  assign sel = div_taps[tac[1:0]] & tac[2];

  always_ff @(posedge clk1) begin
    if (reset) sel_q <= 1'b0;
    else       sel_q <= sel;
  end

`ifdef TIMER_TESTMODE_EN
  assign tick = (sel_q & ~sel) | ff60_d1;
`else
  assign tick = sel_q & ~sel;
`endif

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: TIMA/TMA/TAC registers, overflow-reload FSM and interrupt pulse.
// Optional TIMER_TESTMODE_EN adds the ff60_d1 forced-tick input.
module timer_ctrl
  import dmg_timer_pkg::*;
#(
  parameter logic [7:0] TMA_RESET = 8'h00,
  parameter logic [2:0] TAC_RESET = 3'b000
) (
  input  logic       clk1,
  input  logic       reset,
  input  logic [3:0] div_taps,
  input  logic       ff04_ff07,
  input  logic [1:0] addr,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [7:0] d_in,
`ifdef TIMER_TESTMODE_EN
  input  logic       ff60_d1,
`endif
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       int_timer
);

  t_timer_state state_q, state_d;
  logic [7:0]   tima_q, tima_d;
  logic [7:0]   tma_q, tma_d;
  logic [2:0]   tac_q, tac_d;
  logic [7:0]   reload_base;
  logic         tick;
  logic         wr_hit, wr_tima, wr_tma, wr_tac;

  timer_tap_edge u_tap_edge (
    .clk1     (clk1),
    .reset    (reset),
    .div_taps (div_taps),
    .tac      (tac_q),
`ifdef TIMER_TESTMODE_EN
    .ff60_d1  (ff60_d1),
`endif
    .tick     (tick)
  );

  assign wr_hit  = cpu_wr & ff04_ff07;
  assign wr_tima = wr_hit & (addr == A_TIMA);
  assign wr_tma  = wr_hit & (addr == A_TMA);
  assign wr_tac  = wr_hit & (addr == A_TAC);

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q <= IDLE;
      tima_q  <= 8'h00;
      tma_q   <= TMA_RESET;
      tac_q   <= TAC_RESET;
    end else begin
      state_q <= state_d;
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tima_d      = tima_q;
    tma_d       = wr_tma ? d_in : tma_q;
    tac_d       = wr_tac ? d_in[2:0] : tac_q;
    reload_base = tima_q;
    case (state_q)
      IDLE: begin
        if (wr_tima) begin
          tima_d = d_in;
        end else if (tick) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = OVF;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      OVF: begin
        // A CPU write to TIMA here cancels both the reload and the interrupt.
        if (wr_tima) begin
          tima_d  = d_in;
          state_d = IDLE;
        end else begin
          tima_d  = tma_q;
          state_d = RELOAD;
        end
      end
      RELOAD: begin
        // TIMA follows TMA writes this cycle; direct TIMA writes are dropped.
        reload_base = wr_tma ? d_in : tima_q;
        tima_d      = reload_base;
        state_d     = IDLE;
        if (tick) begin
          if (reload_base == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = OVF;
          end else begin
            tima_d = reload_base + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign int_timer = (state_q == RELOAD);
  assign d_oe      = cpu_rd & ff04_ff07 & (addr != 2'd0);

  always_comb begin
    case (addr)
      A_TIMA:  d_out = tima_q;
      A_TMA:   d_out = tma_q;
      A_TAC:   d_out = {TAC_READ_PAD, tac_q};
      default: d_out = 8'h00;
    endcase
  end

endmodule
